// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: 1-cycle latency, no combinational in->out path.
// Holds on debug freeze or stall, loads a bubble on flush, and gates misaligned memory ops.
module ex_mem_reg #(
   parameter int NB_WIDTH = 32,
   parameter int NB_REG   = 5
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic                i_stall,
   input  logic                i_flush,
   input  logic [NB_WIDTH-1:0] i_pc,
   input  logic [NB_WIDTH-1:0] i_alu_result,
   input  logic [NB_WIDTH-1:0] i_store_data,
   input  logic [NB_REG-1:0]   i_rd_addr,
   input  logic                i_mem_read,
   input  logic                i_mem_write,
   input  logic [2:0]          i_BHW,
   input  logic                i_reg_write,
   input  logic                i_mem_to_reg,
   input  logic                i_halt,
   output logic [NB_WIDTH-1:0] o_pc,
   output logic [NB_WIDTH-1:0] o_mem_addr,
   output logic [NB_WIDTH-1:0] o_mem_data,
   output logic [NB_REG-1:0]   o_rd_addr,
   output logic                o_mem_read,
   output logic                o_mem_write,
   output logic [2:0]          o_BHW,
   output logic                o_reg_write,
   output logic                o_mem_to_reg,
   output logic                o_halt,
   output logic                o_valid,
   output logic                o_misaligned,
   output logic [NB_WIDTH-1:0] o_bad_addr
);

   logic [NB_WIDTH-1:0] pc_q, pc_d;
   logic [NB_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [NB_WIDTH-1:0] mem_data_q, mem_data_d;
   logic [NB_REG-1:0]   rd_addr_q, rd_addr_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [2:0]          bhw_q, bhw_d;
   logic                reg_write_q, reg_write_d;
   logic                mem_to_reg_q, mem_to_reg_d;
   logic                halt_q, halt_d;
   logic                valid_q, valid_d;
   logic                misaligned_q, misaligned_d;
   logic [NB_WIDTH-1:0] bad_addr_q, bad_addr_d;

   logic                aligned;
   logic                misaligned_in;

   // Undefined size codes are treated as word accesses for the alignment check.
   always_comb begin
      aligned = 1'b1;
      case (i_BHW)
         3'b000, 3'b100: aligned = 1'b1;
         3'b001, 3'b101: aligned = (i_alu_result[0] == 1'b0);
         default:        aligned = (i_alu_result[1:0] == 2'b00);
      endcase
      misaligned_in = (i_mem_read | i_mem_write) & ~aligned;
   end

   always_comb begin
      pc_d         = pc_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      rd_addr_d    = rd_addr_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      bhw_d        = bhw_q;
      reg_write_d  = reg_write_q;
      mem_to_reg_d = mem_to_reg_q;
      halt_d       = halt_q;
      valid_d      = valid_q;
      misaligned_d = misaligned_q;
      bad_addr_d   = bad_addr_q;
      if (i_enable) begin
         if (i_flush) begin
            pc_d         = '0;
            mem_addr_d   = '0;
            mem_data_d   = '0;
            rd_addr_d    = '0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            bhw_d        = 3'b000;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            halt_d       = 1'b0;
            valid_d      = 1'b0;
         end else if (!i_stall) begin
            pc_d         = i_pc;
            mem_addr_d   = i_alu_result;
            mem_data_d   = i_store_data;
            rd_addr_d    = i_rd_addr;
            mem_read_d   = i_mem_read & ~misaligned_in;
            mem_write_d  = i_mem_write & ~misaligned_in;
            bhw_d        = i_BHW;
            reg_write_d  = i_reg_write & ~misaligned_in;
            mem_to_reg_d = i_mem_to_reg;
            halt_d       = i_halt;
            valid_d      = 1'b1;
            if (misaligned_in) begin
               misaligned_d = 1'b1;
               if (!misaligned_q) bad_addr_d = i_alu_result;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc_q         <= '0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         rd_addr_q    <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         bhw_q        <= 3'b000;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         halt_q       <= 1'b0;
         valid_q      <= 1'b0;
         misaligned_q <= 1'b0;
         bad_addr_q   <= '0;
      end else begin
         pc_q         <= pc_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         rd_addr_q    <= rd_addr_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         bhw_q        <= bhw_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         halt_q       <= halt_d;
         valid_q      <= valid_d;
         misaligned_q <= misaligned_d;
         bad_addr_q   <= bad_addr_d;
      end
   end

   assign o_pc         = pc_q;
   assign o_mem_addr   = mem_addr_q;
   assign o_mem_data   = mem_data_q;
   assign o_rd_addr    = rd_addr_q;
   assign o_mem_read   = mem_read_q;
   assign o_mem_write  = mem_write_q;
   assign o_BHW        = bhw_q;
   assign o_reg_write  = reg_write_q;
   assign o_mem_to_reg = mem_to_reg_q;
   assign o_halt       = halt_q;
   assign o_valid      = valid_q;
   assign o_misaligned = misaligned_q;
   assign o_bad_addr   = bad_addr_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Table-driven bench for ex_mem_reg: one row per clock edge, plus hand-written corner sequences.
module tb_ex_mem_reg;

   typedef struct packed {
      logic        rst, en, stall, flush;
      logic [31:0] pc, alu, sd;
      logic [4:0]  rd;
      logic        mr, mw;
      logic [2:0]  bhw;
      logic        rw, m2r, halt;
   } ins_t;

   typedef struct packed {
      logic [31:0] pc, addr, data;
      logic [4:0]  rd;
      logic        mr, mw;
      logic [2:0]  bhw;
      logic        rw, m2r, halt, valid, mis;
      logic [31:0] bad;
   } outs_t;

   typedef struct {
      string name;
      ins_t  in;
      outs_t exp;
   } vec_t;

   logic        clk = 1'b0;
   ins_t        drv;
   logic [31:0] o_pc, o_mem_addr, o_mem_data, o_bad_addr;
   logic [4:0]  o_rd_addr;
   logic [2:0]  o_BHW;
   logic        o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg, o_halt, o_valid, o_misaligned;
   outs_t       act;
   int          n_tests = 0;
   int          n_fail  = 0;
   vec_t        vecs[$];

   always #5 clk = ~clk;

   ex_mem_reg #(.NB_WIDTH(32), .NB_REG(5)) dut (
      .i_clk(clk), .i_reset(drv.rst), .i_enable(drv.en), .i_stall(drv.stall), .i_flush(drv.flush),
      .i_pc(drv.pc), .i_alu_result(drv.alu), .i_store_data(drv.sd), .i_rd_addr(drv.rd),
      .i_mem_read(drv.mr), .i_mem_write(drv.mw), .i_BHW(drv.bhw), .i_reg_write(drv.rw),
      .i_mem_to_reg(drv.m2r), .i_halt(drv.halt),
      .o_pc(o_pc), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_rd_addr(o_rd_addr),
      .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_BHW(o_BHW), .o_reg_write(o_reg_write),
      .o_mem_to_reg(o_mem_to_reg), .o_halt(o_halt), .o_valid(o_valid), .o_misaligned(o_misaligned),
      .o_bad_addr(o_bad_addr)
   );

   assign act = '{o_pc, o_mem_addr, o_mem_data, o_rd_addr, o_mem_read, o_mem_write, o_BHW,
                  o_reg_write, o_mem_to_reg, o_halt, o_valid, o_misaligned, o_bad_addr};

   function automatic ins_t ci(logic rst, logic en, logic st, logic fl,
                               logic [31:0] pc, logic [31:0] alu, logic [31:0] sd, logic [4:0] rd,
                               logic mr, logic mw, logic [2:0] bhw, logic rw, logic m2r, logic hlt);
      ins_t r;
      r = '{rst, en, st, fl, pc, alu, sd, rd, mr, mw, bhw, rw, m2r, hlt};
      return r;
   endfunction

   function automatic outs_t co(logic [31:0] pc, logic [31:0] addr, logic [31:0] data, logic [4:0] rd,
                                logic mr, logic mw, logic [2:0] bhw, logic rw, logic m2r, logic hlt,
                                logic vld, logic mis, logic [31:0] bad);
      outs_t r;
      r = '{pc, addr, data, rd, mr, mw, bhw, rw, m2r, hlt, vld, mis, bad};
      return r;
   endfunction

   function automatic void add(string n, ins_t i, outs_t o);
      vec_t v;
      v.name = n; v.in = i; v.exp = o;
      vecs.push_back(v);
   endfunction

   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input ins_t i);
      @(negedge clk);
      drv = i;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string n, input outs_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic check_bit(input string n, input logic got, input logic exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", n, got, exp);
      end
   endtask

   initial begin
      outs_t z;
      z = '0;
      drv = '0;

      add("reset",          ci(1,1,0,0, 32'h0,   32'h0,  32'h0,    0, 0,0,3'b000, 0,0,0), z);
      add("lw_load",        ci(0,1,0,0, 32'h100, 32'h10, 32'hAAAA, 5, 1,0,3'b011, 1,1,0),
                            co(32'h100, 32'h10, 32'hAAAA, 5, 1,0,3'b011, 1,1,0, 1,0, 32'h0));
      add("stall_1",        ci(0,1,1,0, 32'h104, 32'h20, 32'hBBBB, 6, 0,1,3'b011, 0,0,0),
                            co(32'h100, 32'h10, 32'hAAAA, 5, 1,0,3'b011, 1,1,0, 1,0, 32'h0));
      add("stall_2",        ci(0,1,1,0, 32'h108, 32'h24, 32'hCCCC, 7, 1,0,3'b000, 1,0,1),
                            co(32'h100, 32'h10, 32'hAAAA, 5, 1,0,3'b011, 1,1,0, 1,0, 32'h0));
      add("stall_3_misal",  ci(0,1,1,0, 32'h10C, 32'h31, 32'hDDDD, 8, 0,1,3'b011, 0,0,0),
                            co(32'h100, 32'h10, 32'hAAAA, 5, 1,0,3'b011, 1,1,0, 1,0, 32'h0));
      add("stall_release",  ci(0,1,0,0, 32'h104, 32'h20, 32'hBBBB, 6, 0,1,3'b011, 0,0,0),
                            co(32'h104, 32'h20, 32'hBBBB, 6, 0,1,3'b011, 0,0,0, 1,0, 32'h0));
      add("flush_and_stall",ci(0,1,1,1, 32'h108, 32'h31, 32'hCCCC, 0, 0,1,3'b011, 0,0,0), z);
      add("sh_misaligned",  ci(0,1,0,0, 32'h10C, 32'h13, 32'h1234, 0, 0,1,3'b001, 0,0,0),
                            co(32'h10C, 32'h13, 32'h1234, 0, 0,0,3'b001, 0,0,0, 1,1, 32'h13));
      add("lw_misal_2nd",   ci(0,1,0,0, 32'h110, 32'h22, 32'h0,    7, 1,0,3'b011, 1,1,0),
                            co(32'h110, 32'h22, 32'h0,    7, 0,0,3'b011, 0,1,0, 1,1, 32'h13));
      add("reset_2",        ci(1,1,0,0, 32'h0,   32'h0,  32'h0,    0, 0,0,3'b000, 0,0,0), z);
      add("lb_odd_aligned", ci(0,1,0,0, 32'h114, 32'h3,  32'h0,    8, 1,0,3'b000, 1,1,0),
                            co(32'h114, 32'h3,  32'h0,    8, 1,0,3'b000, 1,1,0, 1,0, 32'h0));
      add("no_mem_op_odd",  ci(0,1,0,0, 32'h118, 32'h6,  32'h5,    9, 0,0,3'b011, 1,0,0),
                            co(32'h118, 32'h6,  32'h5,    9, 0,0,3'b011, 1,0,0, 1,0, 32'h0));
      add("flush_misal_ign",ci(0,1,0,1, 32'h11C, 32'h7,  32'h9,    1, 0,1,3'b011, 0,0,0), z);
      add("stall_misal_ign",ci(0,1,1,0, 32'h11C, 32'h7,  32'h9,    1, 0,1,3'b011, 0,0,0), z);
      add("hu_even_ok",     ci(0,1,0,0, 32'h120, 32'h6,  32'h0,    2, 1,0,3'b101, 1,1,0),
                            co(32'h120, 32'h6,  32'h0,    2, 1,0,3'b101, 1,1,0, 1,0, 32'h0));
      add("undef_code_mis", ci(0,1,0,0, 32'h124, 32'h2,  32'h0,   10, 1,0,3'b111, 1,1,0),
                            co(32'h124, 32'h2,  32'h0,   10, 0,0,3'b111, 0,1,0, 1,1, 32'h2));
      add("hu_odd_halt",    ci(0,1,0,0, 32'h128, 32'h5,  32'h0,   11, 1,0,3'b101, 1,1,1),
                            co(32'h128, 32'h5,  32'h0,   11, 0,0,3'b101, 0,1,1, 1,1, 32'h2));
      add("freeze_flush_1", ci(0,0,0,1, 32'h12C, 32'h40, 32'h1,   12, 0,1,3'b011, 0,0,0),
                            co(32'h128, 32'h5,  32'h0,   11, 0,0,3'b101, 0,1,1, 1,1, 32'h2));
      add("freeze_flush_2", ci(0,0,1,1, 32'h130, 32'h41, 32'h2,   13, 1,0,3'b011, 1,1,0),
                            co(32'h128, 32'h5,  32'h0,   11, 0,0,3'b101, 0,1,1, 1,1, 32'h2));
      add("reset_frozen",   ci(1,0,0,1, 32'h134, 32'h43, 32'h3,   14, 1,0,3'b011, 1,1,1), z);

      foreach (vecs[k]) begin
         step(vecs[k].in);
         check(vecs[k].name, vecs[k].exp);
      end

      // Reset arriving while the register is stalled with a valid halt slot.
      step(ci(0,1,0,0, 32'h200, 32'h80, 32'h77, 3, 0,1,3'b011, 0,0,1));
      check("seq_sw_halt", co(32'h200, 32'h80, 32'h77, 3, 0,1,3'b011, 0,0,1, 1,0, 32'h0));
      step(ci(0,1,1,0, 32'h204, 32'h81, 32'h78, 4, 0,1,3'b011, 0,0,0));
      check_bit("seq_stall_keeps_halt", o_halt, 1'b1);
      step(ci(1,1,1,0, 32'h204, 32'h81, 32'h78, 4, 0,1,3'b011, 0,0,0));
      check("seq_reset_mid_stall", z);

      // Halt is not sticky: the next loaded slot without halt clears it.
      step(ci(0,1,0,0, 32'h208, 32'h84, 32'h0, 5, 0,0,3'b011, 0,0,1));
      check_bit("seq_halt_set", o_halt, 1'b1);
      step(ci(0,1,0,0, 32'h20C, 32'h88, 32'h0, 6, 0,0,3'b011, 0,0,0));
      check_bit("seq_halt_clear", o_halt, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
